// File: rtl/mult_pkg.sv
// Shared types and limits for the sequential shift-add multiplier.
package mult_pkg;

  // Supported operand widths.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Controller states; 2'b11 is never entered and falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mult_state_t;

  // True when an operand width lies inside the supported range.
  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/rca_adder.sv
// Ripple-carry adder assembled from single-bit full-adder cells.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // One bit of sum and carry.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

module rca_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry[i]),
      .sum (sum[i]),
      .cout(carry[i+1])
    );
  end

endmodule

// File: rtl/seq_mult.sv
// Multi-cycle shift-add multiplier: one partial-product row per clock through
// a single ripple-carry adder. Signed operations run on magnitudes and the
// sign is applied to the final product.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("seq_mult: WIDTH must lie between WIDTH_MIN and WIDTH_MAX");
  end

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]      LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE    = 1;
  localparam logic [WIDTH-1:0]   ONE_W      = 1;
  localparam logic [2*WIDTH-1:0] ONE_2W     = 1;

  mult_state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplr;
  logic [WIDTH-1:0]   acc_hi;
  logic [CW-1:0]      count;
  logic               neg;

  logic               accept;
  logic               step;
  logic               last;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   add_sum;
  logic               add_cout;
  logic [WIDTH:0]     row_sum;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   mplr_next;
  logic [2*WIDTH-1:0] raw_prod;
  logic [2*WIDTH-1:0] final_prod;

  rca_adder #(.WIDTH(WIDTH)) u_add (
    .a   (acc_hi),
    .b   (mcand),
    .cin (1'b0),
    .sum (add_sum),
    .cout(add_cout)
  );

  // Operand magnitudes at accept time, and the shift-add row for this cycle.
  always_comb begin
    a_mag      = (is_signed && a[WIDTH-1]) ? (~a + ONE_W) : a;
    b_mag      = (is_signed && b[WIDTH-1]) ? (~b + ONE_W) : b;
    row_sum    = mplr[0] ? {add_cout, add_sum} : {1'b0, acc_hi};
    acc_next   = row_sum[WIDTH:1];
    mplr_next  = {row_sum[0], mplr[WIDTH-1:1]};
    raw_prod   = {acc_next, mplr_next};
    final_prod = neg ? (~raw_prod + ONE_2W) : raw_prod;
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode and state-only outputs.
  always_comb begin
    state_next = IDLE;
    accept     = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready   = 1'b1;
        accept     = in_valid;
        state_next = in_valid ? RUN : IDLE;
      end
      RUN: begin
        busy       = 1'b1;
        step       = 1'b1;
        last       = (count == LAST_COUNT);
        state_next = last ? DONE : RUN;
      end
      DONE: begin
        busy       = 1'b1;
        out_valid  = 1'b1;
        state_next = out_ready ? IDLE : DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load magnitudes on accept, shift-add in RUN, capture the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplr    <= '0;
      acc_hi  <= '0;
      count   <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplr   <= b_mag;
      neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_hi <= '0;
      count  <= '0;
    end else if (step) begin
      acc_hi <= acc_next;
      mplr   <= mplr_next;
      count  <= count + CNT_ONE;
      if (last) product <= final_prod;
    end
  end

endmodule
